// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter: state encoding,
// frame geometry and default line timing.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_START,
    ST_SEND,
    ST_ACK,
    ST_WAIT_IDLE
  } ps2_state_t;

  // Start, 8 data, parity, stop; the device ack arrives on the clock after the frame.
  localparam int FRAME_LEN   = 11;
  localparam int PARITY_EDGE = 9;
  localparam int STOP_EDGE   = 10;
  localparam int ACK_EDGE    = 11;

  // 100 us inhibit and 15 ms response window at 50 MHz.
  localparam int DEF_INHIBIT_CYC = 5000;
  localparam int DEF_TIMEOUT_CYC = 750000;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for one raw PS/2 line plus a falling-edge pulse taken
// from the synchronised level. Flops reset to 1, the idle level of the bus.
module ps2_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic line_in,
  output logic line_sync,
  output logic fall
);

  logic meta_p0;
  logic sync_p1;
  logic prev_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      prev_p2 <= 1'b1;
    end else begin
      meta_p0 <= line_in;
      sync_p1 <= meta_p0;
      prev_p2 <= sync_p1;
    end
  end

  assign line_sync = sync_p1;
  assign fall      = prev_p2 & ~sync_p1;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host transmitter: inhibits the clock, issues a request-to-send, shifts a
// command byte out on device-generated clock edges and checks the device ack.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYC = DEF_INHIBIT_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       tx_done,
  output logic       tx_error,
  output logic       busy
);

  localparam int INH_W  = $clog2(INHIBIT_CYC + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_CYC + 2);
  localparam int EDGE_W = $clog2(FRAME_LEN + 1);

  ps2_state_t state, state_nxt;

  logic              clk_sync, clk_fall;
  logic              dat_sync, dat_fall_unused;
  logic [INH_W-1:0]  inh_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [EDGE_W-1:0] edge_cnt;
  logic [EDGE_W-1:0] edge_idx;
  logic [8:0]        shreg;
  logic              dat_q;
  logic              done_nxt, err_nxt;
  logic              done_q, err_q;
  logic              inh_done, tmo_hit, active;

  ps2_line_sync u_clk_sync (
    .clk       (CLOCK_50),
    .rst_n     (resetn),
    .line_in   (ps2_clk_in),
    .line_sync (clk_sync),
    .fall      (clk_fall)
  );

  ps2_line_sync u_dat_sync (
    .clk       (CLOCK_50),
    .rst_n     (resetn),
    .line_in   (ps2_dat_in),
    .line_sync (dat_sync),
    .fall      (dat_fall_unused)
  );

  assign edge_idx = edge_cnt + EDGE_W'(1);
  assign inh_done = (inh_cnt == INH_W'(INHIBIT_CYC - 1));
  // >= so a timeout that lands while a state hands over is still honoured.
  assign tmo_hit  = (tmo_cnt >= TMO_W'(TIMEOUT_CYC - 1));
  assign active   = (state == ST_SEND) || (state == ST_ACK) || (state == ST_WAIT_IDLE);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state  <= ST_IDLE;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= done_nxt;
      err_q  <= err_nxt;
    end
  end

  // Protocol progress takes priority; the timeout only fires when nothing advanced.
  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (cmd_valid) state_nxt = ST_INHIBIT;
      end
      ST_INHIBIT: begin
        if (inh_done) state_nxt = ST_START;
      end
      ST_START: begin
        state_nxt = ST_SEND;
      end
      ST_SEND: begin
        if (clk_fall && (edge_idx == EDGE_W'(STOP_EDGE))) begin
          state_nxt = ST_ACK;
        end else if (tmo_hit) begin
          state_nxt = ST_IDLE;
          err_nxt   = 1'b1;
        end
      end
      ST_ACK: begin
        if (clk_fall && (edge_idx == EDGE_W'(ACK_EDGE))) begin
          if (!dat_sync) begin
            state_nxt = ST_WAIT_IDLE;
          end else begin
            state_nxt = ST_IDLE;
            err_nxt   = 1'b1;
          end
        end else if (tmo_hit) begin
          state_nxt = ST_IDLE;
          err_nxt   = 1'b1;
        end
      end
      ST_WAIT_IDLE: begin
        if (clk_sync && dat_sync) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end else if (tmo_hit) begin
          state_nxt = ST_IDLE;
          err_nxt   = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      inh_cnt  <= '0;
      tmo_cnt  <= '0;
      edge_cnt <= '0;
      dat_q    <= 1'b0;
    end else begin
      inh_cnt <= (state == ST_INHIBIT) ? inh_cnt + INH_W'(1) : '0;

      if (state == ST_START)  tmo_cnt <= '0;
      else if (active)        tmo_cnt <= tmo_cnt + TMO_W'(1);

      if (state == ST_START) begin
        edge_cnt <= '0;
      end else if (clk_fall && ((state == ST_SEND) || (state == ST_ACK))) begin
        edge_cnt <= edge_idx;
      end

      // dat_q holds the start bit low until the first device clock falls.
      if (state == ST_START) begin
        dat_q <= 1'b1;
      end else if ((state == ST_SEND) && clk_fall) begin
        dat_q <= (edge_idx <= EDGE_W'(PARITY_EDGE)) ? ~shreg[0] : 1'b0;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if ((state == ST_IDLE) && cmd_valid) begin
      shreg <= {odd_parity(cmd_data), cmd_data};
    end else if ((state == ST_SEND) && clk_fall && (edge_idx <= EDGE_W'(PARITY_EDGE))) begin
      shreg <= {1'b0, shreg[8:1]};
    end
  end

  assign cmd_ready  = (state == ST_IDLE) && resetn;
  assign busy       = (state != ST_IDLE);
  assign ps2_clk_oe = (state == ST_INHIBIT) || (state == ST_START);
  assign ps2_dat_oe = (state == ST_START) || ((state == ST_SEND) && dat_q);
  assign tx_done    = done_q;
  assign tx_error   = err_q;

endmodule
